// File: rtl/accum_int64_gather.sv
// accum_int64_gather: gathers BEAT-wide operand beats into a LANES-slot batch and issues it to the int64 accumulator
// Optional macro ACC_GATHER_PERF_EN adds perf_batches / perf_stall counter outputs.
module accum_int64_gather #(
    parameter int LANES   = 108,
    parameter int BEAT    = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [BEAT-1:0][63:0]  in_data,
    input  logic [BEAT-1:0]        in_lane_en,
    input  logic [63:0]            in_A,
    input  logic                   in_last,
    output logic [63:0]            acc_A,
    output logic [LANES-1:0][63:0] acc_B,
    output logic                   acc_din_en,
    input  logic                   acc_res_en,
    output logic [2:0]             outstanding,
`ifdef ACC_GATHER_PERF_EN
    output logic [31:0]            perf_batches,
    output logic [31:0]            perf_stall,
`endif
    output logic                   err_spurious
);
    localparam int NB = LANES / BEAT;
    localparam int IW = $clog2(NB + 1);
    typedef enum logic {FILL, ISSUE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] beat_idx;
    logic accept;
    // state register
    always_ff @(posedge clk) state <= rst ? FILL : state_nx;
    // next state: close the batch on in_last or on the final beat slot
    always_comb state_nx = state == ISSUE ? FILL : (accept && (in_last || beat_idx == IW'(NB - 1))) ? ISSUE : FILL;
    // outputs: issue strobe, throttled ready, beat acceptance
    always_comb begin
        in_rdy     = state == FILL && outstanding < 3'(MAX_OUT);
        acc_din_en = state == ISSUE;
        accept     = in_vld && in_rdy;
    end
    // staging buffer doubles as acc_B; cleared on the edge leaving ISSUE
    always_ff @(posedge clk) begin
        if (rst || acc_din_en) begin
            acc_B    <= '0;
            beat_idx <= '0;
        end else if (accept) begin
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < BEAT; k++)
                    if (beat_idx == IW'(b)) acc_B[b*BEAT+k] <= in_lane_en[k] ? in_data[k] : 64'd0;
            beat_idx <= beat_idx + 1'b1;
        end
    end
    // scalar operand captured on the first beat of a batch
    always_ff @(posedge clk) begin
        if (rst) acc_A <= '0;
        else if (accept && beat_idx == '0) acc_A <= in_A;
    end
    // in-flight batch count and sticky spurious-return flag
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding  <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (acc_res_en && outstanding == '0) err_spurious <= 1'b1;
            if (acc_din_en && !acc_res_en) outstanding <= outstanding + 1'b1;
            else if (!acc_din_en && acc_res_en && outstanding != '0) outstanding <= outstanding - 1'b1;
        end
    end
`ifdef ACC_GATHER_PERF_EN
    // issued-batch counter (wrapping) and stall-cycle counter (saturating)
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_batches <= '0;
            perf_stall   <= '0;
        end else begin
            if (acc_din_en) perf_batches <= perf_batches + 1'b1;
            if (in_vld && !in_rdy && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_accum_int64_gather.sv
// tb_accum_int64_gather: directed stimulus with a batch-level reference model for accum_int64_gather
module tb_accum_int64_gather;
    localparam int LANES = 108, BEAT = 4, MAX_OUT = 2, NB = LANES / BEAT;
    logic clk = 0, rst = 1, in_vld = 0, in_last = 0, acc_res_en = 0;
    logic [BEAT-1:0] in_lane_en = '0;
    logic [BEAT-1:0][63:0] in_data = '0;
    logic [63:0] in_A = '0;
    logic in_rdy, acc_din_en, err_spurious;
    logic [63:0] acc_A;
    logic [LANES-1:0][63:0] acc_B;
    logic [2:0] outstanding;
`ifdef ACC_GATHER_PERF_EN
    logic [31:0] perf_batches, perf_stall;
    logic [31:0] m_batches, m_stall;
`endif
    int checks = 0, errors = 0, bad;
    logic [63:0] m_slots [LANES];
    logic [63:0] m_A;
    int m_beats, m_out;
    bit m_issue, m_err, was_issue, m_acc;
    wire m_rdy = !m_issue && m_out < MAX_OUT;

    accum_int64_gather #(.LANES(LANES), .BEAT(BEAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_lane_en(in_lane_en), .in_A(in_A), .in_last(in_last), .acc_A(acc_A), .acc_B(acc_B),
        .acc_din_en(acc_din_en), .acc_res_en(acc_res_en), .outstanding(outstanding),
`ifdef ACC_GATHER_PERF_EN
        .perf_batches(perf_batches), .perf_stall(perf_stall),
`endif
        .err_spurious(err_spurious));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference model: a batch is a list of slots filled beat by beat, issued one cycle after closing
    always @(posedge clk) begin
        if (rst) begin
            foreach (m_slots[i]) m_slots[i] = '0;
            m_A = '0; m_beats = 0; m_out = 0; m_issue = 0; m_err = 0;
`ifdef ACC_GATHER_PERF_EN
            m_batches = '0; m_stall = '0;
`endif
        end else begin
            was_issue = m_issue;
            m_acc = in_vld && m_rdy;
`ifdef ACC_GATHER_PERF_EN
            if (in_vld && !m_rdy && m_stall != 32'hFFFFFFFF) m_stall++;
            if (was_issue) m_batches++;
`endif
            if (was_issue) begin
                foreach (m_slots[i]) m_slots[i] = '0;
                m_beats = 0;
                m_issue = 0;
            end else if (m_acc) begin
                for (int k = 0; k < BEAT; k++) m_slots[m_beats*BEAT+k] = in_lane_en[k] ? in_data[k] : 64'd0;
                if (m_beats == 0) m_A = in_A;
                m_beats++;
                if (in_last || m_beats == NB) m_issue = 1;
            end
            if (acc_res_en && m_out == 0) m_err = 1;
            if (was_issue && !acc_res_en) m_out++;
            else if (!was_issue && acc_res_en && m_out > 0) m_out--;
        end
    end

    // every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_rdy", in_rdy, m_rdy);
            chk("acc_din_en", acc_din_en, m_issue);
            chk("outstanding", outstanding, m_out);
            chk("err_spurious", err_spurious, m_err);
`ifdef ACC_GATHER_PERF_EN
            chk("perf_batches", perf_batches, m_batches);
            chk("perf_stall", perf_stall, m_stall);
`endif
            if (m_issue) begin
                chk("acc_A", acc_A, m_A);
                bad = -1;
                for (int i = 0; i < LANES; i++) if (bad < 0 && acc_B[i] !== m_slots[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL acc_B slot %0d: got %h expected %h", bad, acc_B[bad], m_slots[bad]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [BEAT-1:0][63:0] d, input logic [BEAT-1:0] en, input logic [63:0] a, input logic last);
        int n = 0;
        in_vld = 1; in_data = d; in_lane_en = en; in_A = a; in_last = last;
        while (!in_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("beat_wait_timeout", n < 50, 1);
        tick();
        in_vld = 0; in_last = 0;
    endtask

    task automatic pulse_res();
        acc_res_en = 1;
        tick();
        acc_res_en = 0;
    endtask

    logic [BEAT-1:0][63:0] d;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_in_rdy", in_rdy, 1);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_din_en", acc_din_en, 0);
        chk("reset_acc_A", acc_A, 0);
        chk("reset_acc_B0", acc_B[0], 0);
        // full batch: 27 beats, data = slot index
        for (int n = 0; n < NB; n++) begin
            for (int k = 0; k < BEAT; k++) d[k] = 64'(n * BEAT + k);
            beat(d, 4'hF, 64'h5, 0);
        end
        chk("full_din_en", acc_din_en, 1);
        chk("full_acc_A", acc_A, 64'h5);
        chk("full_B0", acc_B[0], 64'd0);
        chk("full_B50", acc_B[50], 64'd50);
        chk("full_B107", acc_B[107], 64'd107);
        tick();
        chk("full_outstanding", outstanding, 1);
        chk("full_din_drop", acc_din_en, 0);
        pulse_res();
        chk("ret_outstanding", outstanding, 0);
        // short batch: lanes 0 and 2 only, closed by in_last on the third beat
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < BEAT; k++) d[k] = 64'(100 + n * BEAT + k);
            beat(d, 4'b0101, 64'h77, n == 2);
        end
        chk("short_din_en", acc_din_en, 1);
        chk("short_acc_A", acc_A, 64'h77);
        chk("short_B0", acc_B[0], 64'd100);
        chk("short_B1", acc_B[1], 64'd0);
        chk("short_B10", acc_B[10], 64'd110);
        chk("short_B11", acc_B[11], 64'd0);
        chk("short_B12", acc_B[12], 64'd0);
        tick();
        // throttle: second unreturned batch reaches MAX_OUT
        for (int k = 0; k < BEAT; k++) d[k] = 64'(200 + k);
        beat(d, 4'hF, 64'h9, 1);
        tick();
        chk("thr_outstanding", outstanding, 2);
        for (int k = 0; k < BEAT; k++) d[k] = 64'(300 + k);
        in_vld = 1; in_data = d; in_lane_en = 4'hF; in_A = 64'hA; in_last = 1;
        repeat (3) tick();
        chk("thr_in_rdy_low", in_rdy, 0);
        pulse_res();
        chk("thr_in_rdy_high", in_rdy, 1);
        chk("thr_outstanding_1", outstanding, 1);
        tick();
        in_vld = 0; in_last = 0;
        chk("thr_din_en", acc_din_en, 1);
        chk("thr_B0", acc_B[0], 64'd300);
        // simultaneous issue and return keeps the count
        pulse_res();
        chk("sim_outstanding", outstanding, 1);
        pulse_res();
        chk("drain_outstanding", outstanding, 0);
        // spurious return
        pulse_res();
        chk("spur_err", err_spurious, 1);
        chk("spur_outstanding", outstanding, 0);
        repeat (3) tick();
        chk("spur_sticky", err_spurious, 1);
        // reset mid-batch discards partial data
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < BEAT; k++) d[k] = 64'(500 + n * BEAT + k);
            beat(d, 4'hF, 64'hB, 0);
        end
        rst = 1;
        tick();
        rst = 0;
        chk("rst_err_clear", err_spurious, 0);
        chk("rst_no_din", acc_din_en, 0);
        for (int k = 0; k < BEAT; k++) d[k] = 64'(900 + k);
        beat(d, 4'hF, 64'hC, 1);
        chk("rst_din_en", acc_din_en, 1);
        chk("rst_B3", acc_B[3], 64'd903);
        chk("rst_B4", acc_B[4], 64'd0);
        chk("rst_B39", acc_B[39], 64'd0);
        tick();
`ifdef ACC_GATHER_PERF_EN
        chk("perf_batches_after_rst", perf_batches, 1);
`endif
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
